// File: rtl/logic_sweep_unit.sv
// rtl/logic_sweep_unit.sv - registered bitwise function unit with self-check sweep (optional parity port: LOGIC_SWEEP_PARITY_EN)
module logic_sweep_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] signature
`ifdef LOGIC_SWEEP_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int CW = 2 * WIDTH;
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CW-1:0]    cnt;
    logic [1:0]       op_latched;
    logic [WIDTH-1:0] idle_val;
    logic [WIDTH-1:0] sweep_val;
    logic [WIDTH-1:0] sig_rot;
    logic             accept;

    function automatic logic [WIDTH-1:0] apply_op(
        input logic [1:0]       sel,
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        case (sel)
            2'd0:    apply_op = x & y;
            2'd1:    apply_op = x | y;
            2'd2:    apply_op = x ^ y;
            default: apply_op = ~(x & y);
        endcase
    endfunction

    // Abort beats start so a simultaneous cancel never launches a sweep.
    assign accept    = start && !abort;
    assign idle_val  = apply_op(op, a, b);
    // Low half of the counter is operand A, high half operand B.
    assign sweep_val = apply_op(op_latched, cnt[WIDTH-1:0], cnt[CW-1:WIDTH]);
    // Shift-or form degenerates to identity when WIDTH is 1.
    assign sig_rot   = (signature << 1) | (signature >> (WIDTH - 1));
    assign busy      = (state == SWEEP);
    assign done      = (state == DONE);

    // State register; everything freezes while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= next_state;
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SWEEP;
            SWEEP: begin
                if (abort)     next_state = IDLE;
                else if (&cnt) next_state = DONE;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath: normal-mode result in IDLE, sweep walk and signature fold in SWEEP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result     <= '0;
            valid      <= 1'b0;
            signature  <= '0;
            cnt        <= '0;
            op_latched <= 2'd0;
`ifdef LOGIC_SWEEP_PARITY_EN
            parity     <= 1'b0;
`endif
        end else if (ena) begin
            case (state)
                IDLE: begin
                    result <= idle_val;
                    valid  <= !accept;
`ifdef LOGIC_SWEEP_PARITY_EN
                    parity <= ^idle_val;
`endif
                    if (accept) begin
                        op_latched <= op;
                        cnt        <= '0;
                        signature  <= '0;
                    end
                end
                SWEEP: begin
                    valid <= 1'b0;
                    // An aborted edge processes nothing: partial signature and cnt hold.
                    if (!abort) begin
                        result    <= sweep_val;
                        signature <= sig_rot ^ sweep_val;
                        cnt       <= cnt + CNT_ONE;
`ifdef LOGIC_SWEEP_PARITY_EN
                        parity    <= ^sweep_val;
`endif
                    end
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_sweep_unit.sv
// tb/tb_logic_sweep_unit.sv - randomized self-checking bench for logic_sweep_unit
module tb_logic_sweep_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena;
    logic [3:0] a, b;
    logic [1:0] op;
    logic       start, abort;
    logic [3:0] result, signature;
    logic       valid, busy, done;

    logic       a1, b1;
    logic [1:0] op1;
    logic       start1, abort1;
    logic       result1, signature1, valid1, busy1, done1;

`ifdef LOGIC_SWEEP_PARITY_EN
    logic parity, parity1;
`endif

    logic_sweep_unit #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .a(a), .b(b), .op(op),
        .start(start), .abort(abort), .result(result), .valid(valid),
        .busy(busy), .done(done), .signature(signature)
`ifdef LOGIC_SWEEP_PARITY_EN
        , .parity(parity)
`endif
    );

    logic_sweep_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .a(a1), .b(b1), .op(op1),
        .start(start1), .abort(abort1), .result(result1), .valid(valid1),
        .busy(busy1), .done(done1), .signature(signature1)
`ifdef LOGIC_SWEEP_PARITY_EN
        , .parity(parity1)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int fop(input int sel, input int x, input int y, input int w);
        int mask = (1 << w) - 1;
        case (sel)
            0:       return x & y;
            1:       return x | y;
            2:       return x ^ y;
            default: return (~(x & y)) & mask;
        endcase
    endfunction

    function automatic int rotl(input int s, input int w);
        return ((s << 1) | (s >> (w - 1))) & ((1 << w) - 1);
    endfunction

    // Signature after folding the first n operand combinations.
    function automatic int sweep_sig(input int sel, input int w, input int n);
        int s = 0;
        for (int i = 0; i < n; i++)
            s = rotl(s, w) ^ fop(sel, i % (1 << w), i / (1 << w), w);
        return s;
    endfunction

    // Reference model of the WIDTH=4 instance: mode 0 idle, 1 sweeping, 2 done.
    int m_mode = 0, m_idx = 0, m_sig = 0, m_res = 0, m_valid = 0, m_op = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_idx = 0; m_sig = 0; m_res = 0; m_valid = 0; m_op = 0;
        end else if (ena) begin
            if (m_mode == 0) begin
                m_res   = fop(op, a, b, 4);
                m_valid = 1;
                if (start && !abort) begin
                    m_op = op; m_idx = 0; m_sig = 0; m_mode = 1; m_valid = 0;
                end
            end else if (m_mode == 1) begin
                if (abort) m_mode = 0;
                else begin
                    m_res = fop(m_op, m_idx % 16, m_idx / 16, 4);
                    m_sig = rotl(m_sig, 4) ^ m_res;
                    if (m_idx == 255) m_mode = 2;
                    m_idx++;
                end
            end else begin
                m_mode = 0;
            end
        end
    end

    // Continuous comparison of the WIDTH=4 instance against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_result", result, m_res);
            check("cyc_valid", valid, m_valid);
            check("cyc_busy", busy, m_mode == 1);
            check("cyc_done", done, m_mode == 2);
            check("cyc_signature", signature, m_sig);
`ifdef LOGIC_SWEEP_PARITY_EN
            check("cyc_parity", parity, ^m_res[3:0]);
`endif
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    int exp_r[4] = '{8, 14, 6, 7};
    int exp_p[4] = '{1, 1, 0, 1};
    int sop, edges;

    initial begin
        rst_n = 0; ena = 0; a = 0; b = 0; op = 0; start = 0; abort = 0;
        a1 = 0; b1 = 0; op1 = 0; start1 = 0; abort1 = 0;
        #1 chk_en = 1;
        repeat (3) tick;
        check("rst_result", result, 0);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_signature", signature, 0);
        rst_n = 1;
        ena   = 1;

        // Fixed operand pattern across all four functions.
        a = 4'hC; b = 4'hA;
        for (int o = 0; o < 4; o++) begin
            op = 2'(o);
            tick;
            check("op_result", result, exp_r[o]);
            check("op_valid", valid, 1);
`ifdef LOGIC_SWEEP_PARITY_EN
            check("op_parity", parity, exp_p[o]);
`endif
        end

        // Random normal-mode traffic with ena toggling.
        repeat (60) begin
            a = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
            ena = ($urandom_range(0, 3) != 0); abort = 1'($urandom);
            tick;
        end
        ena = 1; abort = 0;

        // Full sweep with a 10-edge ena pause and noise on ignored inputs.
        sop = $urandom_range(0, 3);
        op = 2'(sop); start = 1;
        tick;
        start = 0; edges = -1;
        for (int i = 1; i <= 400 && edges < 0; i++) begin
            ena   = !(i >= 50 && i < 60);
            a     = 4'($urandom); b = 4'($urandom); op = 2'($urandom);
            start = 1'($urandom);
            tick;
            if (done) edges = i;
        end
        start = 0; ena = 1;
        check("pause_done_edge", edges, 266);
        check("pause_signature", signature, sweep_sig(sop, 4, 256));
        tick;
        check("done_one_cycle", done, 0);
        check("sig_hold", signature, sweep_sig(sop, 4, 256));

        // Abort 20 edges into a sweep.
        sop = $urandom_range(0, 3);
        op = 2'(sop); start = 1;
        tick;
        start = 0;
        repeat (20) tick;
        abort = 1;
        tick;
        abort = 0;
        check("abort_busy", busy, 0);
        check("abort_partial_sig", signature, sweep_sig(sop, 4, 20));
        repeat (5) begin
            tick;
            check("abort_no_done", done, 0);
        end

        // Start and abort together in IDLE.
        start = 1; abort = 1;
        tick;
        start = 0; abort = 0;
        check("start_abort_busy", busy, 0);
        check("start_abort_valid", valid, 1);

        // Reset in the middle of a sweep, then a clean rerun.
        sop = $urandom_range(0, 3);
        op = 2'(sop); start = 1;
        tick;
        start = 0;
        repeat (30) tick;
        rst_n = 0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_signature", signature, 0);
        check("mid_rst_result", result, 0);
        tick;
        rst_n = 1;
        tick;
        start = 1;
        tick;
        start = 0; edges = -1;
        for (int i = 1; i <= 300 && edges < 0; i++) begin
            tick;
            if (done) edges = i;
        end
        check("rerun_done_edge", edges, 256);
        check("rerun_signature", signature, sweep_sig(sop, 4, 256));
        tick;

        // WIDTH=1 instance: AND sweep timing and signature.
        op1 = 0; start1 = 1;
        tick;
        start1 = 0;
        check("w1_busy_first", busy1, 1);
        repeat (3) begin
            tick;
            check("w1_busy", busy1, 1);
            check("w1_no_done", done1, 0);
        end
        tick;
        check("w1_done", done1, 1);
        check("w1_busy_off", busy1, 0);
        check("w1_and_sig", signature1, 1);
        tick;
        check("w1_done_drop", done1, 0);
        check("w1_sig_hold", signature1, 1);

        // WIDTH=1 XOR sweep.
        op1 = 2; start1 = 1;
        tick;
        start1 = 0;
        repeat (5) tick;
        check("w1_xor_sig", signature1, 0);

        // WIDTH=1 op change mid-sweep keeps the latched AND.
        op1 = 0; start1 = 1;
        tick;
        start1 = 0; op1 = 2;
        repeat (4) tick;
        check("w1_latched_done", done1, 1);
        check("w1_latched_sig", signature1, 1);
        tick;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
